// File: rtl/exec_sequencer.sv
// Y86-64 execute-stage sequencer: captures one decoded instruction, drives the
// shared ALU over three cycles, then publishes valE, Cnd and the condition codes.
module exec_sequencer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] valE,
  output logic         Cnd,
  output logic [2:0]   cc,
  output logic         err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_fun,
  input  logic [W-1:0] alu_out,
  input  logic         alu_of
);

  typedef enum logic [1:0] {IDLE, SETUP, EVAL, DONE} state_t;

  localparam logic [3:0]   FUN_ADD   = 4'd0;
  localparam logic [3:0]   IC_CMOV   = 4'h2;
  localparam logic [3:0]   IC_OPQ    = 4'h6;
  localparam logic [3:0]   IC_JXX    = 4'h7;
  localparam logic [3:0]   IC_LAST   = 4'hB;
  localparam logic [W-1:0] STACK_DEC = ~W'(7);
  localparam logic [W-1:0] STACK_INC = W'(8);
  localparam logic [2:0]   CC_RESET  = 3'b100;

  state_t       state, state_nxt;
  logic         capture;
  logic [3:0]   icode_q, ifun_q;
  logic [W-1:0] val_a_q, val_b_q, val_c_q;

  logic [W-1:0] sel_a, sel_b;
  logic [3:0]   sel_fun;
  logic [W-1:0] val_e_nxt;
  logic [2:0]   cc_nxt;
  logic         cnd_nxt, err_nxt;
  logic         zf, sf, of;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign {zf, sf, of} = cc;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (start) begin
               capture   = 1'b1;
               state_nxt = SETUP;
             end
      SETUP: state_nxt = EVAL;
      EVAL:  state_nxt = DONE;
      DONE:  begin
               capture   = start;
               state_nxt = start ? SETUP : IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_fun = FUN_ADD;
    case (icode_q)
      4'h2:       sel_a = val_a_q;
      4'h3:       sel_a = val_c_q;
      4'h4, 4'h5: begin sel_a = val_c_q;   sel_b = val_b_q; end
      4'h6:       begin sel_a = val_a_q;   sel_b = val_b_q; sel_fun = {2'b00, ifun_q[1:0]}; end
      4'h8, 4'hA: begin sel_a = STACK_DEC; sel_b = val_b_q; end
      4'h9, 4'hB: begin sel_a = STACK_INC; sel_b = val_b_q; end
      default: ;
    endcase
  end

  // Conditions read cc as it stands before this instruction; only OPq rewrites it,
  // and OPq never consults the condition.
  always_comb begin
    val_e_nxt = alu_out;
    cc_nxt    = cc;
    cnd_nxt   = 1'b1;
    err_nxt   = 1'b0;
    if (icode_q > IC_LAST) begin
      val_e_nxt = '0;
      cnd_nxt   = 1'b0;
      err_nxt   = 1'b1;
    end else if (icode_q == IC_OPQ) begin
      cc_nxt = {(alu_out == '0), alu_out[W-1], alu_of};
    end else if (icode_q == IC_CMOV || icode_q == IC_JXX) begin
      case (ifun_q)
        4'd0: cnd_nxt = 1'b1;
        4'd1: cnd_nxt = (sf ^ of) | zf;
        4'd2: cnd_nxt = sf ^ of;
        4'd3: cnd_nxt = zf;
        4'd4: cnd_nxt = ~zf;
        4'd5: cnd_nxt = ~(sf ^ of);
        4'd6: cnd_nxt = ~(sf ^ of) & ~zf;
        default: begin
          cnd_nxt = 1'b0;
          err_nxt = 1'b1;
        end
      endcase
    end
  end

  // NOTE: every register here updates with <= so all reads in this edge see
  // pre-edge values; blocking assignments would let later lines see new ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      icode_q <= '0;
      ifun_q  <= '0;
      val_a_q <= '0;
      val_b_q <= '0;
      val_c_q <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= FUN_ADD;
      valE    <= '0;
      Cnd     <= 1'b0;
      err     <= 1'b0;
      cc      <= CC_RESET;
    end else begin
      state <= state_nxt;
      if (capture) begin
        icode_q <= icode;
        ifun_q  <= ifun;
        val_a_q <= valA;
        val_b_q <= valB;
        val_c_q <= valC;
      end
      if (state == SETUP) begin
        alu_a   <= sel_a;
        alu_b   <= sel_b;
        alu_fun <= sel_fun;
      end
      if (state == EVAL) begin
        valE <= val_e_nxt;
        cc   <= cc_nxt;
        Cnd  <= cnd_nxt;
        err  <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table of instructions issued back to back
// through DONE, plus hand sequences for ignored start and mid-operation reset.
module tb_exec_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [3:0]   icode, ifun;
  logic [W-1:0] valA, valB, valC;
  logic         busy, done, Cnd, err, alu_of;
  logic [W-1:0] valE, alu_a, alu_b, alu_out;
  logic [2:0]   cc;
  logic [3:0]   alu_fun;

  int errors = 0;
  int checks = 0;

  exec_sequencer #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .busy(busy), .done(done),
    .valE(valE), .Cnd(Cnd), .cc(cc), .err(err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fun(alu_fun), .alu_out(alu_out), .alu_of(alu_of)
  );

  always #5 clk = ~clk;

  // Shared ALU: result = alu_b OP alu_a
  always_comb begin
    alu_out = '0;
    alu_of  = 1'b0;
    case (alu_fun)
      4'd0: begin
        alu_out = alu_b + alu_a;
        alu_of  = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_b[W-1]);
      end
      4'd1: begin
        alu_out = alu_b - alu_a;
        alu_of  = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_b[W-1]);
      end
      4'd2: alu_out = alu_b & alu_a;
      4'd3: alu_out = alu_b ^ alu_a;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] a, b, c;
    logic [W-1:0] exp_alu_a, exp_alu_b;
    logic [3:0]   exp_fun;
    logic [W-1:0] exp_val_e;
    logic         exp_cnd;
    logic [2:0]   exp_cc;
    logic         exp_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [W-1:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // Called at a negedge; issues one instruction and returns at the negedge of its DONE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    icode = v.icode; ifun = v.ifun; valA = v.a; valB = v.b; valC = v.c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d busy_setup", idx), W'(busy), W'(1));
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      if (lat == 2) begin
        check($sformatf("v%0d alu_a", idx), alu_a, v.exp_alu_a);
        check($sformatf("v%0d alu_b", idx), alu_b, v.exp_alu_b);
        check($sformatf("v%0d alu_fun", idx), W'(alu_fun), W'(v.exp_fun));
      end
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", idx), W'(lat), W'(3));
    check($sformatf("v%0d valE", idx), valE, v.exp_val_e);
    check($sformatf("v%0d Cnd", idx), W'(Cnd), W'(v.exp_cnd));
    check($sformatf("v%0d cc", idx), W'(cc), W'(v.exp_cc));
    check($sformatf("v%0d err", idx), W'(err), W'(v.exp_err));
  endtask

  initial begin
    int n_done;
    reset_n = 1'b0; start = 1'b0;
    icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;

    //            icode ifun a            b       c        alu_a     alu_b   fun   valE      cnd cc      err
    vecs.push_back(vec_t'{4'h6, 4'h0, 64'd3,  64'd5,  64'd0,   64'd3,    64'd5,  4'd0, 64'd8,    1, 3'b000, 0});
    vecs.push_back(vec_t'{4'h6, 4'h1, 64'd7,  64'd7,  64'd0,   64'd7,    64'd7,  4'd1, 64'd0,    1, 3'b100, 0});
    vecs.push_back(vec_t'{4'h7, 4'h3, 64'd0,  64'd0,  64'h40,  64'd0,    64'd0,  4'd0, 64'd0,    1, 3'b100, 0});
    vecs.push_back(vec_t'{4'h6, 4'h0, 64'd1,  MAXP,   64'd0,   64'd1,    MAXP,   4'd0, MINN,     1, 3'b011, 0});
    vecs.push_back(vec_t'{4'h7, 4'h2, 64'd0,  64'd0,  64'h40,  64'd0,    64'd0,  4'd0, 64'd0,    0, 3'b011, 0});
    vecs.push_back(vec_t'{4'h7, 4'h6, 64'd0,  64'd0,  64'h40,  64'd0,    64'd0,  4'd0, 64'd0,    1, 3'b011, 0});
    vecs.push_back(vec_t'{4'hA, 4'h0, 64'd0,  64'h100,64'd0,   NEG8,     64'h100,4'd0, 64'hF8,   1, 3'b011, 0});
    vecs.push_back(vec_t'{4'hB, 4'h0, 64'd0,  64'hF8, 64'd0,   64'd8,    64'hF8, 4'd0, 64'h100,  1, 3'b011, 0});
    vecs.push_back(vec_t'{4'hC, 4'h0, 64'd5,  64'd6,  64'd7,   64'd0,    64'd0,  4'd0, 64'd0,    0, 3'b011, 1});
    vecs.push_back(vec_t'{4'h2, 4'h7, 64'h55, 64'd0,  64'd0,   64'h55,   64'd0,  4'd0, 64'h55,   0, 3'b011, 1});
    vecs.push_back(vec_t'{4'h2, 4'h1, 64'h1234,64'd0, 64'd0,   64'h1234, 64'd0,  4'd0, 64'h1234, 0, 3'b011, 0});
    vecs.push_back(vec_t'{4'h3, 4'h0, 64'd0,  64'd0,  64'hABC, 64'hABC,  64'd0,  4'd0, 64'hABC,  1, 3'b011, 0});
    vecs.push_back(vec_t'{4'h5, 4'h0, 64'd0,  64'h20, 64'h10,  64'h10,   64'h20, 4'd0, 64'h30,   1, 3'b011, 0});
    vecs.push_back(vec_t'{4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0,   64'hF0,   64'h3C, 4'd2, 64'h30,   1, 3'b000, 0});
    vecs.push_back(vec_t'{4'h6, 4'h3, 64'd5,  64'd5,  64'd0,   64'd5,    64'd5,  4'd3, 64'd0,    1, 3'b100, 0});
    vecs.push_back(vec_t'{4'h2, 4'h4, 64'd9,  64'd0,  64'd0,   64'd9,    64'd0,  4'd0, 64'd9,    0, 3'b100, 0});
    vecs.push_back(vec_t'{4'h6, 4'h1, 64'd1,  64'd0,  64'd0,   64'd1,    64'd0,  4'd1, ONES,     1, 3'b010, 0});
    vecs.push_back(vec_t'{4'h7, 4'h5, 64'd0,  64'd0,  64'd0,   64'd0,    64'd0,  4'd0, 64'd0,    0, 3'b010, 0});
    vecs.push_back(vec_t'{4'h7, 4'h1, 64'd0,  64'd0,  64'd0,   64'd0,    64'd0,  4'd0, 64'd0,    1, 3'b010, 0});
    vecs.push_back(vec_t'{4'h1, 4'h0, 64'd3,  64'd4,  64'd5,   64'd0,    64'd0,  4'd0, 64'd0,    1, 3'b010, 0});
    vecs.push_back(vec_t'{4'h8, 4'h0, 64'd0,  64'h200,64'd0,   NEG8,     64'h200,4'd0, 64'h1F8,  1, 3'b010, 0});
    vecs.push_back(vec_t'{4'h6, 4'h0, 64'd1,  ONES,   64'd0,   64'd1,    ONES,   4'd0, 64'd0,    1, 3'b100, 0});

    repeat (3) @(negedge clk);
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    check("rst cc", W'(cc), W'(3'b100));
    check("rst valE", valE, W'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Issued back to back: each new start lands in the previous DONE cycle
    foreach (vecs[i]) run_vec(vecs[i], i);
    @(negedge clk);
    check("idle after table", W'(busy), W'(0));

    // start pulsed in SETUP and EVAL of a push must be ignored
    icode = 4'hA; ifun = 4'h0; valA = '0; valB = 64'h100; valC = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    icode = 4'h6; valA = 64'd1; valB = 64'd2;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = (done === 1'b1) ? 1 : 0;
    check("push valE", valE, 64'hF8);
    check("push cc", W'(cc), W'(3'b100));
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("push done count", W'(n_done), W'(1));
    check("push idle", W'(busy), W'(0));

    // Reset in EVAL of an OPq; start held during reset
    icode = 4'h6; ifun = 4'h1; valA = 64'd2; valB = 64'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    check("mid rst busy", W'(busy), W'(0));
    check("mid rst done", W'(done), W'(0));
    check("mid rst valE", valE, W'(0));
    check("mid rst Cnd", W'(Cnd), W'(0));
    check("mid rst err", W'(err), W'(0));
    check("mid rst cc", W'(cc), W'(3'b100));
    check("mid rst alu_a", alu_a, W'(0));
    check("mid rst alu_b", alu_b, W'(0));
    check("mid rst alu_fun", W'(alu_fun), W'(0));
    @(negedge clk);
    check("start in rst busy", W'(busy), W'(0));
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    check("after rst done", W'(done), W'(0));
    run_vec(vec_t'{4'h6, 4'h0, 64'd3, 64'd5, 64'd0, 64'd3, 64'd5, 4'd0, 64'd8, 1, 3'b000, 0}, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
